// File: rtl/divided_clock_monitor_pkg.sv
// Shared definitions for the divided-clock monitor and the memory clock divider
// it checks: state encoding, default widths and the ratio-to-half-period rule.
package divided_clock_monitor_pkg;

  localparam int DEF_CNT_W = 10;
  localparam int DEF_ERR_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    MEASURE = 2'd2
  } mon_state_e;

  // A divider programmed with ratio N holds each level for N+1 master clocks.
  function automatic logic [DEF_CNT_W-1:0] expected_half(input int unsigned ratio);
    return DEF_CNT_W'(ratio + 1);
  endfunction

endpackage

// File: rtl/divided_clock_monitor_clk_edge_detect.sv
// Registers a clk-synchronous divided clock and flags any level change; the
// registered copy doubles as the level of the phase that just ended.
module divided_clock_monitor_clk_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic edge_det,
  output logic prev_level
);

  logic sig_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sig_q <= 1'b0;
    else        sig_q <= sig;
  end

  assign edge_det   = sig ^ sig_q;
  assign prev_level = sig_q;

endmodule

// File: rtl/divided_clock_monitor.sv
// Measures each half-period of one divided clock in master clk cycles, checks it
// against an expected value and reports drift, error count and stalls.
module divided_clock_monitor
  import divided_clock_monitor_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TOL     = 4,
  parameter int TIMEOUT = 1000,
  parameter int ERR_W   = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enabled,
  input  logic             mon_clk,
  input  logic [CNT_W-1:0] expect_half,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_level,
  output logic             meas_valid,
  output logic             in_range,
  output logic             stall,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]        CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]        TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [ERR_W-1:0]        ERR_ONE   = ERR_W'(1);
  localparam logic [ERR_W-1:0]        ERR_MAX   = '1;
  localparam logic signed [CNT_W:0]   TOL_S     = (CNT_W+1)'(TOL);

  mon_state_e       state, state_nxt;
  logic [CNT_W-1:0] run_cnt, run_cnt_nxt;
  logic [CNT_W-1:0] half_period_nxt;
  logic             meas_level_nxt;
  logic             meas_valid_nxt;
  logic             in_range_nxt;
  logic             stall_nxt;
  logic [ERR_W-1:0] err_cnt_nxt;

  logic             edge_det;
  logic             mon_q;
  logic signed [CNT_W:0] diff;
  logic             within_tol;

  divided_clock_monitor_clk_edge_detect u_edge (
    .clk        (clk),
    .reset      (reset),
    .sig        (mon_clk),
    .edge_det   (edge_det),
    .prev_level (mon_q)
  );

  // One extra bit keeps the unsigned operands' difference exact in two's complement.
  assign diff       = $signed({1'b0, run_cnt}) - $signed({1'b0, expect_half});
  assign within_tol = (diff >= -TOL_S) && (diff <= TOL_S);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      run_cnt     <= '0;
      half_period <= '0;
      meas_level  <= 1'b0;
      meas_valid  <= 1'b0;
      in_range    <= 1'b0;
      stall       <= 1'b0;
      err_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      run_cnt     <= run_cnt_nxt;
      half_period <= half_period_nxt;
      meas_level  <= meas_level_nxt;
      meas_valid  <= meas_valid_nxt;
      in_range    <= in_range_nxt;
      stall       <= stall_nxt;
      err_cnt     <= err_cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_nxt       = state;
    run_cnt_nxt     = run_cnt;
    half_period_nxt = half_period;
    meas_level_nxt  = meas_level;
    meas_valid_nxt  = 1'b0;
    in_range_nxt    = in_range;
    stall_nxt       = stall;
    err_cnt_nxt     = err_cnt;

    if (!enabled) begin
      state_nxt   = IDLE;
      run_cnt_nxt = '0;
    end else begin
      unique case (state)
        IDLE: state_nxt = SYNC;

        // The first edge only aligns the counter; the phase before it is partial.
        SYNC: begin
          if (edge_det) begin
            run_cnt_nxt = CNT_ONE;
            stall_nxt   = 1'b0;
            state_nxt   = MEASURE;
          end
        end

        MEASURE: begin
          if (edge_det) begin
            half_period_nxt = run_cnt;
            meas_level_nxt  = mon_q;
            meas_valid_nxt  = 1'b1;
            in_range_nxt    = within_tol;
            run_cnt_nxt     = CNT_ONE;
            if (!within_tol && err_cnt != ERR_MAX) err_cnt_nxt = err_cnt + ERR_ONE;
          end else if (run_cnt == TIMEOUT_C) begin
            stall_nxt   = 1'b1;
            run_cnt_nxt = '0;
            state_nxt   = SYNC;
          end else if (run_cnt != CNT_MAX) begin
            run_cnt_nxt = run_cnt + CNT_ONE;
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divided_clock_monitor.sv
// Directed bench for divided_clock_monitor: nominal, tolerance, error saturation,
// asymmetric duty, stall/recovery, enable gating and asynchronous reset.
module tb_divided_clock_monitor;
  import divided_clock_monitor_pkg::*;

  logic       clk;
  logic       reset;
  logic       enabled;
  logic       mon_clk;
  logic [9:0] expect_half;
  logic [9:0] half_period;
  logic       meas_level;
  logic       meas_valid;
  logic       in_range;
  logic       stall;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  int hi_len   = 101;
  int lo_len   = 101;
  int ph_cnt   = 0;
  bit toggling = 1'b0;

  divided_clock_monitor #(
    .CNT_W   (10),
    .TOL     (4),
    .TIMEOUT (300),
    .ERR_W   (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enabled     (enabled),
    .mon_clk     (mon_clk),
    .expect_half (expect_half),
    .half_period (half_period),
    .meas_level  (meas_level),
    .meas_valid  (meas_valid),
    .in_range    (in_range),
    .stall       (stall),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clk cycle; mon_clk holds each level for hi_len/lo_len cycles.
  task automatic step();
    @(posedge clk);
    #1;
    if (toggling) begin
      ph_cnt++;
      if (ph_cnt >= (mon_clk ? hi_len : lo_len)) begin
        mon_clk = ~mon_clk;
        ph_cnt  = 0;
      end
    end
  endtask

  task automatic wait_meas(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      step();
      n++;
      if (meas_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic start_toggle(input int h, input int l);
    hi_len   = h;
    lo_len   = l;
    ph_cnt   = 0;
    toggling = 1'b1;
  endtask

  task automatic do_reset();
    toggling = 1'b0;
    mon_clk  = 1'b0;
    enabled  = 1'b0;
    reset    = 1'b0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enabled = 1'b0; mon_clk = 1'b0; expect_half = 10'd0;
    #3;
    n_checks++; if (half_period !== 10'd0) $display("FAIL rst_half: got %0d expected 0", half_period); else n_pass++;
    n_checks++; if (meas_level !== 1'b0) $display("FAIL rst_level: got %b expected 0", meas_level); else n_pass++;
    n_checks++; if (meas_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", meas_valid); else n_pass++;
    n_checks++; if (in_range !== 1'b0) $display("FAIL rst_in_range: got %b expected 0", in_range); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b expected 0", stall); else n_pass++;
    n_checks++; if (err_cnt !== 8'd0) $display("FAIL rst_err: got %0d expected 0", err_cnt); else n_pass++;
  endtask

  task automatic test_nominal();
    int n;
    bit ok;
    logic exp_level;
    do_reset();
    expect_half = expected_half(100);
    enabled = 1'b1;
    start_toggle(101, 101);
    // Edge at step 102 only syncs; first measurement lands at step 203.
    wait_meas(400, n, ok);
    n_checks++; if (n !== 203) $display("FAIL nom_first_latency: got %0d expected 203", n); else n_pass++;
    n_checks++; if (half_period !== 10'd101) $display("FAIL nom_half: got %0d expected 101", half_period); else n_pass++;
    n_checks++; if (in_range !== 1'b1) $display("FAIL nom_in_range: got %b expected 1", in_range); else n_pass++;
    n_checks++; if (meas_level !== 1'b1) $display("FAIL nom_level: got %b expected 1", meas_level); else n_pass++;
    exp_level = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (meas_valid !== 1'b0) $display("FAIL nom_pulse_width: got %b expected 0", meas_valid); else n_pass++;
      wait_meas(200, n, ok);
      exp_level = ~exp_level;
      n_checks++; if (n !== 100) $display("FAIL nom_spacing: got %0d expected 100", n); else n_pass++;
      n_checks++; if (half_period !== 10'd101) $display("FAIL nom_half_loop: got %0d expected 101", half_period); else n_pass++;
      n_checks++; if (meas_level !== exp_level) $display("FAIL nom_level_loop: got %b expected %b", meas_level, exp_level); else n_pass++;
      n_checks++; if (err_cnt !== 8'd0) $display("FAIL nom_err: got %0d expected 0", err_cnt); else n_pass++;
    end
  endtask

  // Continues the 101-cycle stream; retargets expect_half between edges.
  task automatic test_tolerance();
    logic [9:0] exp_tab [4] = '{10'd97, 10'd105, 10'd96, 10'd106};
    logic       inr_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] err_tab [4] = '{8'd0, 8'd0, 8'd1, 8'd2};
    int n;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      expect_half = exp_tab[i];
      wait_meas(200, n, ok);
      n_checks++; if (!ok) $display("FAIL tol_timeout: got no pulse expected pulse (case %0d)", i); else n_pass++;
      n_checks++; if (in_range !== inr_tab[i]) $display("FAIL tol_in_range[%0d]: got %b expected %b", i, in_range, inr_tab[i]); else n_pass++;
      n_checks++; if (err_cnt !== err_tab[i]) $display("FAIL tol_err[%0d]: got %0d expected %0d", i, err_cnt, err_tab[i]); else n_pass++;
    end
  endtask

  task automatic test_out_of_range();
    int n;
    bit ok;
    logic [7:0] exp_err;
    do_reset();
    expect_half = 10'd101;
    enabled = 1'b1;
    start_toggle(110, 110);
    for (int k = 1; k <= 300; k++) begin
      wait_meas(250, n, ok);
      n_checks++;
      if (!ok) begin
        $display("FAIL oor_timeout: got no pulse expected pulse (edge %0d)", k);
        break;
      end
      n_pass++;
      exp_err = (k > 255) ? 8'd255 : 8'(k);
      if (k <= 3 || k == 255 || k == 256 || k == 300) begin
        n_checks++; if (err_cnt !== exp_err) $display("FAIL oor_err[%0d]: got %0d expected %0d", k, err_cnt, exp_err); else n_pass++;
        n_checks++; if (half_period !== 10'd110) $display("FAIL oor_half[%0d]: got %0d expected 110", k, half_period); else n_pass++;
        n_checks++; if (in_range !== 1'b0) $display("FAIL oor_in_range[%0d]: got %b expected 0", k, in_range); else n_pass++;
      end
    end
  endtask

  task automatic test_asymmetric();
    int n;
    bit ok;
    logic       lvl_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [9:0] hp_tab  [4] = '{10'd50, 10'd60, 10'd50, 10'd60};
    do_reset();
    expect_half = 10'd55;
    enabled = 1'b1;
    start_toggle(50, 60);
    for (int i = 0; i < 4; i++) begin
      wait_meas(300, n, ok);
      n_checks++; if (!ok) $display("FAIL asym_timeout: got no pulse expected pulse (meas %0d)", i); else n_pass++;
      n_checks++; if (meas_level !== lvl_tab[i]) $display("FAIL asym_level[%0d]: got %b expected %b", i, meas_level, lvl_tab[i]); else n_pass++;
      n_checks++; if (half_period !== hp_tab[i]) $display("FAIL asym_half[%0d]: got %0d expected %0d", i, half_period, hp_tab[i]); else n_pass++;
      n_checks++; if (in_range !== 1'b0) $display("FAIL asym_in_range[%0d]: got %b expected 0", i, in_range); else n_pass++;
      n_checks++; if (err_cnt !== 8'(i + 1)) $display("FAIL asym_err[%0d]: got %0d expected %0d", i, err_cnt, i + 1); else n_pass++;
    end
  endtask

  task automatic test_stall();
    int n;
    bit ok;
    bit early;
    do_reset();
    expect_half = 10'd300;
    enabled = 1'b1;
    // A 300-cycle phase makes the edge coincide with run_cnt == TIMEOUT.
    start_toggle(300, 300);
    wait_meas(700, n, ok);
    n_checks++; if (n !== 601) $display("FAIL stall_edge_wins_latency: got %0d expected 601", n); else n_pass++;
    n_checks++; if (half_period !== 10'd300) $display("FAIL stall_edge_wins_half: got %0d expected 300", half_period); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL stall_edge_wins_stall: got %b expected 0", stall); else n_pass++;
    toggling = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 299; i++) begin
      step();
      if (stall !== 1'b0 || meas_valid !== 1'b0) early = 1'b1;
    end
    n_checks++; if (early) $display("FAIL stall_early: got stall/valid before 300 cycles expected none"); else n_pass++;
    step();
    n_checks++; if (stall !== 1'b1) $display("FAIL stall_at_timeout: got %b expected 1", stall); else n_pass++;
    early = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (stall !== 1'b1 || meas_valid !== 1'b0) early = 1'b1;
    end
    n_checks++; if (early) $display("FAIL stall_sticky: got stall drop or pulse expected steady stall"); else n_pass++;
    enabled = 1'b0;
    repeat (3) step();
    enabled = 1'b1;
    repeat (2) step();
    n_checks++; if (stall !== 1'b1) $display("FAIL stall_enable_toggle: got %b expected 1", stall); else n_pass++;
    hi_len = 101; lo_len = 101; ph_cnt = 0;
    mon_clk  = ~mon_clk;
    toggling = 1'b1;
    step();
    n_checks++; if (stall !== 1'b0) $display("FAIL stall_clear: got %b expected 0", stall); else n_pass++;
    n_checks++; if (meas_valid !== 1'b0) $display("FAIL stall_resync_pulse: got %b expected 0", meas_valid); else n_pass++;
    wait_meas(200, n, ok);
    n_checks++; if (n !== 101) $display("FAIL stall_recover_latency: got %0d expected 101", n); else n_pass++;
    n_checks++; if (half_period !== 10'd101) $display("FAIL stall_recover_half: got %0d expected 101", half_period); else n_pass++;
  endtask

  task automatic test_disable();
    int n;
    bit ok;
    bit bad;
    do_reset();
    expect_half = 10'd101;
    enabled = 1'b1;
    start_toggle(101, 101);
    wait_meas(400, n, ok);
    wait_meas(200, n, ok);
    n_checks++; if (meas_level !== 1'b0) $display("FAIL dis_pre_level: got %b expected 0", meas_level); else n_pass++;
    // Enable falls in the same cycle as an edge: no measurement may result.
    toggling = 1'b0;
    mon_clk  = ~mon_clk;
    enabled  = 1'b0;
    start_toggle(7, 7);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (meas_valid !== 1'b0 || half_period !== 10'd101 || meas_level !== 1'b0 ||
          in_range !== 1'b1 || err_cnt !== 8'd0 || stall !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) $display("FAIL dis_hold: got pulse or changed outputs expected hold"); else n_pass++;
    enabled = 1'b1;
    start_toggle(101, 101);
    wait_meas(400, n, ok);
    n_checks++; if (n !== 203) $display("FAIL dis_resync_latency: got %0d expected 203", n); else n_pass++;
    n_checks++; if (half_period !== 10'd101) $display("FAIL dis_recover_half: got %0d expected 101", half_period); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    do_reset();
    expect_half = 10'd50;
    enabled = 1'b1;
    start_toggle(101, 101);
    wait_meas(400, n, ok);
    expect_half = 10'd101;
    wait_meas(200, n, ok);
    n_checks++; if (err_cnt !== 8'd1 || in_range !== 1'b1) $display("FAIL mid_pre: got err=%0d inr=%b expected err=1 inr=1", err_cnt, in_range); else n_pass++;
    repeat (59) step();
    #2 reset = 1'b0;
    #1;
    n_checks++; if (half_period !== 10'd0) $display("FAIL mid_half: got %0d expected 0", half_period); else n_pass++;
    n_checks++; if (err_cnt !== 8'd0) $display("FAIL mid_err: got %0d expected 0", err_cnt); else n_pass++;
    n_checks++; if (in_range !== 1'b0) $display("FAIL mid_in_range: got %b expected 0", in_range); else n_pass++;
    n_checks++; if (meas_level !== 1'b0 || meas_valid !== 1'b0 || stall !== 1'b0)
      $display("FAIL mid_flags: got lvl=%b vld=%b stl=%b expected 0 0 0", meas_level, meas_valid, stall); else n_pass++;
    #2 reset = 1'b1;
    ph_cnt = 0;
    wait_meas(400, n, ok);
    n_checks++; if (n !== 203) $display("FAIL mid_restart_latency: got %0d expected 203", n); else n_pass++;
    n_checks++; if (half_period !== 10'd101 || in_range !== 1'b1) $display("FAIL mid_restart_meas: got half=%0d inr=%b expected 101 1", half_period, in_range); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_tolerance();
    test_out_of_range();
    test_asymmetric();
    test_stall();
    test_disable();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
